t_sel_arb: RTL and testbench

//  Producer end of the one-hot data-select path: arbitrates three 32-bit result

---
 rtl/t_sel_arb.sv | 120 ++++++++++++
 tb/tb_t_sel_arb.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/t_sel_arb.sv
// rtl/t_sel_arb.sv - three-source one-hot select arbiter with registered output beat
// Define FB_SEL_ARB_FIXPRI_EN for fixed priority 00 > 01 > 11 instead of round-robin.
module t_sel_arb #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req00,
  input  logic          req01,
  input  logic          req11,
  input  logic [DW-1:0] d00,
  input  logic [DW-1:0] d01,
  input  logic [DW-1:0] d11,
  output logic          gnt00,
  output logic          gnt01,
  output logic          gnt11,
  output logic          out_valid,
  output logic [2:0]    out_sel,
  output logic [DW-1:0] out_data,
  input  logic          out_ready
);

  logic [2:0]    req_v;
  logic [2:0]    gnt_v;
  logic          load;
  logic          out_valid_q, out_valid_d;
  logic [2:0]    out_sel_q, out_sel_d;
  logic [DW-1:0] out_data_q, out_data_d;

  assign req_v = {req11, req01, req00};
  assign load  = ~out_valid_q | out_ready;

`ifdef FB_SEL_ARB_FIXPRI_EN
  always_comb begin
    gnt_v = 3'b000;
    if (!rst && load) begin
      if (req_v[0])      gnt_v = 3'b001;
      else if (req_v[1]) gnt_v = 3'b010;
      else if (req_v[2]) gnt_v = 3'b100;
    end
  end
`else
  // Pointer holds the slot index (0=00, 1=01, 2=11) that is searched first.
  logic [1:0] ptr_q, ptr_d;

  always_comb begin
    gnt_v = 3'b000;
    if (!rst && load) begin
      case (ptr_q)
        2'd1: begin
          if (req_v[1])      gnt_v = 3'b010;
          else if (req_v[2]) gnt_v = 3'b100;
          else if (req_v[0]) gnt_v = 3'b001;
        end
        2'd2: begin
          if (req_v[2])      gnt_v = 3'b100;
          else if (req_v[0]) gnt_v = 3'b001;
          else if (req_v[1]) gnt_v = 3'b010;
        end
        default: begin
          if (req_v[0])      gnt_v = 3'b001;
          else if (req_v[1]) gnt_v = 3'b010;
          else if (req_v[2]) gnt_v = 3'b100;
        end
      endcase
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_v[0])      ptr_d = 2'd1;
    else if (gnt_v[1]) ptr_d = 2'd2;
    else if (gnt_v[2]) ptr_d = 2'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 2'd0;
    else     ptr_q <= ptr_d;
  end
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    out_sel_d   = out_sel_q;
    out_data_d  = out_data_q;
    if (load) begin
      if (|gnt_v) begin
        out_valid_d = 1'b1;
        out_sel_d   = gnt_v;
        if (gnt_v[0])      out_data_d = d00;
        else if (gnt_v[1]) out_data_d = d01;
        else               out_data_d = d11;
      end else begin
        // Empty or drained with nothing to refill: data is left as-is.
        out_valid_d = 1'b0;
        out_sel_d   = 3'b000;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_sel_q   <= 3'b000;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
      out_data_q  <= out_data_d;
    end
  end

  assign gnt00     = gnt_v[0];
  assign gnt01     = gnt_v[1];
  assign gnt11     = gnt_v[2];
  assign out_valid = out_valid_q;
  assign out_sel   = out_sel_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_t_sel_arb.sv
// tb/tb_t_sel_arb.sv - randomized and directed bench for t_sel_arb against a slot-order model
// Honours FB_SEL_ARB_FIXPRI_EN the same way as the design.
module tb_t_sel_arb;

  logic        clk;
  logic        rst;
  logic [2:0]  req_v;
  logic [31:0] d_v [3];
  logic        gnt00, gnt01, gnt11;
  logic        out_valid;
  logic [2:0]  out_sel;
  logic [31:0] out_data;
  logic        out_ready;

  int errors = 0;
  int checks = 0;

  logic        m_valid;
  logic [2:0]  m_sel;
  logic [31:0] m_data;
  int          m_ptr;

  logic [2:0]  g_obs, g_exp;

  t_sel_arb #(.DW(32)) dut (
    .clk(clk), .rst(rst),
    .req00(req_v[0]), .req01(req_v[1]), .req11(req_v[2]),
    .d00(d_v[0]), .d01(d_v[1]), .d11(d_v[2]),
    .gnt00(gnt00), .gnt01(gnt01), .gnt11(gnt11),
    .out_valid(out_valid), .out_sel(out_sel), .out_data(out_data),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Winner is the first requesting slot walking 00,01,11 from the start slot.
  function automatic logic [2:0] model_gnt();
    logic [2:0] g;
    int start;
    int idx;
    g = 3'b000;
`ifdef FB_SEL_ARB_FIXPRI_EN
    start = 0;
`else
    start = m_ptr;
`endif
    if (!rst && (!m_valid || out_ready)) begin
      for (int k = 0; k < 3; k++) begin
        idx = (start + k) % 3;
        if (g == 3'b000 && req_v[idx]) g = 3'b001 << idx;
      end
    end
    return g;
  endfunction

  task automatic model_update(input logic [2:0] g);
    int w;
    if (rst) begin
      m_valid = 1'b0; m_sel = 3'b000; m_data = 32'h0; m_ptr = 0;
    end else if (!m_valid || out_ready) begin
      if (g != 3'b000) begin
        w = g[0] ? 0 : (g[1] ? 1 : 2);
        m_valid = 1'b1; m_sel = g; m_data = d_v[w]; m_ptr = (w + 1) % 3;
      end else begin
        m_valid = 1'b0; m_sel = 3'b000;
      end
    end
  endtask

  task automatic cycle(output logic [2:0] obs, output logic [2:0] exp_g);
    @(negedge clk);
    exp_g = model_gnt();
    obs   = {gnt11, gnt01, gnt00};
    @(posedge clk);
    #1;
    model_update(exp_g);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_v = 3'b000; out_ready = 1'b0;
    cycle(g_obs, g_exp);
    cycle(g_obs, g_exp);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_v = 3'b111; out_ready = 1'b1;
    d_v[0] = 32'h1111_0000; d_v[1] = 32'h2222_0000; d_v[2] = 32'h3333_0000;
    for (int c = 0; c < 2; c++) begin
      cycle(g_obs, g_exp);
      checks++;
      if (g_obs !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b expected 000", g_obs); end
      checks++;
      if (out_valid !== 1'b0 || out_sel !== 3'b000 || out_data !== 32'h0) begin
        errors++; $display("FAIL reset_out: got v=%b sel=%b data=%h expected v=0 sel=000 data=0", out_valid, out_sel, out_data);
      end
    end
    rst = 1'b0; req_v = 3'b000;
  endtask

  task automatic test_single();
    do_reset();
    req_v = 3'b010; d_v[1] = 32'hDEAD_BEEF; out_ready = 1'b1;
    cycle(g_obs, g_exp);
    req_v = 3'b000;
    checks++;
    if (g_obs !== 3'b010) begin errors++; $display("FAIL single_gnt: got %b expected 010", g_obs); end
    checks++;
    if (out_valid !== 1'b1 || out_sel !== 3'b010 || out_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL single_out: got v=%b sel=%b data=%h expected v=1 sel=010 data=deadbeef", out_valid, out_sel, out_data);
    end
  endtask

  task automatic test_rr_fairness();
    logic [2:0] order [3];
`ifdef FB_SEL_ARB_FIXPRI_EN
    order[0] = 3'b001; order[1] = 3'b001; order[2] = 3'b001;
`else
    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100;
`endif
    do_reset();
    req_v = 3'b111; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      d_v[0] = $urandom; d_v[1] = $urandom; d_v[2] = $urandom;
      cycle(g_obs, g_exp);
      checks++;
      if (g_obs !== order[c % 3]) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", c, g_obs, order[c % 3]); end
      checks++;
      if (out_sel !== m_sel || out_data !== m_data) begin
        errors++; $display("FAIL rr_out[%0d]: got sel=%b data=%h expected sel=%b data=%h", c, out_sel, out_data, m_sel, m_data);
      end
    end
    req_v = 3'b000;
  endtask

  task automatic test_backpressure();
    do_reset();
    req_v = 3'b001; d_v[0] = 32'hA5A5_0001; out_ready = 1'b1;
    cycle(g_obs, g_exp);
    req_v = 3'b100; d_v[2] = 32'h5A5A_0011; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cycle(g_obs, g_exp);
      checks++;
      if (g_obs !== 3'b000) begin errors++; $display("FAIL bp_gnt[%0d]: got %b expected 000", c, g_obs); end
      checks++;
      if (out_valid !== 1'b1 || out_sel !== 3'b001 || out_data !== 32'hA5A5_0001) begin
        errors++; $display("FAIL bp_hold[%0d]: got v=%b sel=%b data=%h expected v=1 sel=001 data=a5a50001", c, out_valid, out_sel, out_data);
      end
    end
    out_ready = 1'b1;
    cycle(g_obs, g_exp);
    req_v = 3'b000;
    checks++;
    if (g_obs !== 3'b100) begin errors++; $display("FAIL bp_release_gnt: got %b expected 100", g_obs); end
    checks++;
    if (out_valid !== 1'b1 || out_sel !== 3'b100 || out_data !== 32'h5A5A_0011) begin
      errors++; $display("FAIL bp_release_out: got v=%b sel=%b data=%h expected v=1 sel=100 data=5a5a0011", out_valid, out_sel, out_data);
    end
  endtask

  task automatic test_drain();
    req_v = 3'b000; out_ready = 1'b1;
    cycle(g_obs, g_exp);
    checks++;
    if (out_valid !== 1'b0 || out_sel !== 3'b000 || out_data !== 32'h5A5A_0011) begin
      errors++; $display("FAIL drain: got v=%b sel=%b data=%h expected v=0 sel=000 data=5a5a0011", out_valid, out_sel, out_data);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_v = 3'b001; d_v[0] = 32'hC0DE_0000; out_ready = 1'b1;
    cycle(g_obs, g_exp);
    req_v = 3'b000; out_ready = 1'b0;
    rst = 1'b1; req_v = 3'b111;
    cycle(g_obs, g_exp);
    checks++;
    if (g_obs !== 3'b000) begin errors++; $display("FAIL midrst_gnt: got %b expected 000", g_obs); end
    checks++;
    if (out_valid !== 1'b0 || out_sel !== 3'b000) begin
      errors++; $display("FAIL midrst_out: got v=%b sel=%b expected v=0 sel=000", out_valid, out_sel);
    end
    rst = 1'b0; out_ready = 1'b1;
    cycle(g_obs, g_exp);
    req_v = 3'b000;
    checks++;
    if (g_obs !== 3'b001) begin errors++; $display("FAIL midrst_first_gnt: got %b expected 001", g_obs); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 500; c++) begin
      rst       = ($urandom_range(0, 39) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle(g_obs, g_exp);
      checks++;
      if (g_obs !== g_exp) begin errors++; $display("FAIL rand_gnt[%0d]: got %b expected %b", c, g_obs, g_exp); end
      checks++;
      if (out_valid !== m_valid || out_sel !== m_sel || (m_valid && out_data !== m_data)) begin
        errors++; $display("FAIL rand_out[%0d]: got v=%b sel=%b data=%h expected v=%b sel=%b data=%h",
                          c, out_valid, out_sel, out_data, m_valid, m_sel, m_data);
      end
      for (int i = 0; i < 3; i++) begin
        if (g_obs[i]) req_v[i] = 1'b0;
        if (!req_v[i] && $urandom_range(0, 1) == 1) begin
          req_v[i] = 1'b1;
          d_v[i]   = $urandom;
        end
      end
    end
    rst = 1'b0; req_v = 3'b000;
  endtask

  initial begin
    rst = 1'b1; req_v = 3'b000; out_ready = 1'b0;
    d_v[0] = 32'h0; d_v[1] = 32'h0; d_v[2] = 32'h0;
    m_valid = 1'b0; m_sel = 3'b000; m_data = 32'h0; m_ptr = 0;
    test_reset();
    test_single();
    test_rr_fairness();
    test_backpressure();
    test_drain();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
